// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart transmit arbiter.
// Optional START timeout is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

    localparam int unsigned ID_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

    // Width of a counter that has to hold values 0 .. cycles-1
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Round-robin picker: first set request after the last served index, wrapping.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               valid_c,
    output logic [ID_W-1:0]    idx_c
);

    localparam int unsigned IW = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);

    // Scan last+1, last+2, ... and keep the first hit
    always_comb begin
        int unsigned cand;
        valid_c = 1'b0;
        idx_c   = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last) + k) % NUM_REQ;
            if (!valid_c && req[IW'(cand)]) begin
                valid_c = 1'b1;
                idx_c   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart transmitter among NUM_REQ byte requesters.
// One byte in flight at a time; define UART_ARB_TIMEOUT_EN to abort a START
// that never sees is_transmitting within TIMEOUT_CYCLES.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_byte,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 done,
    output logic                 busy,
    output logic [ID_W-1:0]      busy_id,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    input  logic                 is_transmitting,
    output logic                 error
);

    arb_state_e           state, state_d;
    logic [ID_W-1:0]      last, last_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 done_d, busy_d, transmit_d;
    logic [ID_W-1:0]      busy_id_d;
    logic [7:0]           tx_byte_d;
    logic                 pick_valid;
    logic [ID_W-1:0]      pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 error_q, error_d;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    uart_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .last    (last),
        .valid_c (pick_valid),
        .idx_c   (pick_idx)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        last_d     = last;
        grant_d    = '0;
        done_d     = 1'b0;
        busy_d     = busy;
        busy_id_d  = busy_id;
        transmit_d = transmit;
        tx_byte_d  = tx_byte;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = '0;
        error_d    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A byte still draining on the line blocks new grants
                if (pick_valid && !is_transmitting) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == ID_W'(i)) begin
                            grant_d[i] = 1'b1;
                            tx_byte_d  = req_byte[8*i +: 8];
                        end
                    end
                    transmit_d = 1'b1;
                    busy_d     = 1'b1;
                    busy_id_d  = pick_idx;
                    last_d     = pick_idx;
                    state_d    = START;
                end
            end
            START: begin
                if (is_transmitting) begin
                    transmit_d = 1'b0;
                    state_d    = BUSY;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    transmit_d = 1'b0;
                    busy_d     = 1'b0;
                    error_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
`endif
            end
            BUSY: begin
                if (!is_transmitting) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= ID_W'(NUM_REQ - 1);
            grant    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            busy_id  <= '0;
            transmit <= 1'b0;
            tx_byte  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt      <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            last     <= last_d;
            grant    <= grant_d;
            done     <= done_d;
            busy     <= busy_d;
            busy_id  <= busy_id_d;
            transmit <= transmit_d;
            tx_byte  <= tx_byte_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt      <= cnt_d;
            error_q  <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart model:
// is_transmitting rises 1 clk after transmit and stays high 20 clk.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int          UART_LEN = 20;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [8*NUM_REQ-1:0] req_byte = '0;
    logic [NUM_REQ-1:0]   grant;
    logic                 done, busy, transmit, error;
    logic [2:0]           busy_id;
    logic [7:0]           tx_byte;
    logic                 is_transmitting = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // uart model state
    logic model_en = 1'b1;
    int   tx_cnt   = 0;

    // monitor flags
    bit overlap_err = 1'b0;
    bit onehot_err  = 1'b0;
    bit err_seen    = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_byte        (req_byte),
        .grant           (grant),
        .done            (done),
        .busy            (busy),
        .busy_id         (busy_id),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .error           (error)
    );

    // uart model: one byte per transmit request, independent of arbiter reset
    always @(posedge clk) begin
        if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) is_transmitting <= 1'b0;
        end else if (transmit && model_en) begin
            is_transmitting <= 1'b1;
            tx_cnt          <= UART_LEN;
        end
    end

    // transmit may overlap is_transmitting only in the first cycle of a byte
    always @(negedge clk) begin
        if (transmit && tx_cnt != 0 && tx_cnt < UART_LEN) overlap_err = 1'b1;
        if (grant != '0 && $countones(grant) != 1) onehot_err = 1'b1;
        if (error) err_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input int max, output logic [NUM_REQ-1:0] g);
        g = '0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g = grant;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && !is_transmitting) begin
                ok = 1'b1;
                break;
            end
        end
        check_val(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NUM_REQ-1:0] g;
        int                 n;
        bit                 flag;
        bit                 ok;

        // reset state
        tick(2);
        check_val("reset_outputs",
                  32'({grant, done, busy, busy_id, transmit, tx_byte, error}), 32'd0);
        rst_n = 1'b1;

        // 1: single request from requester 2
        req_byte[23:16] = 8'h41;
        req             = 4'b0100;
        tick(1);
        check_val("t1_grant",    32'(grant), 32'h4);
        check_val("t1_tx_byte",  32'(tx_byte), 32'h41);
        check_val("t1_transmit", 32'({transmit, busy}), 32'h3);
        check_val("t1_busy_id",  32'(busy_id), 32'd2);
        req = '0;
        tick(1);
        check_val("t1_hold_transmit", 32'({transmit, is_transmitting, grant}), 32'h30);
        tick(1);
        check_val("t1_transmit_drop", 32'({transmit, busy}), 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!is_transmitting) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("t1_line_idle", 32'(ok), 32'd1);
        check_val("t1_no_early_done", 32'(done), 32'd0);
        tick(1);
        check_val("t1_done", 32'({done, busy}), 32'h2);
        tick(1);
        check_val("t1_done_pulse", 32'(done), 32'd0);

        // 2: all requesting, rotation starts at requester 0 after reset
        do_reset();
        req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(60, g);
            check_val($sformatf("t2_grant%0d", k), 32'(g), 32'(1 << (k % 4)));
            check_val($sformatf("t2_byte%0d", k), 32'(tx_byte), 32'(8'h10 + (k % 4)));
        end
        req = '0;
        wait_idle("t2_idle", 80);

        // 3: reset while BUSY, line still active afterwards
        req_byte[23:16] = 8'h77;
        req             = 4'b0100;
        wait_grant(10, g);
        check_val("t3_grant", 32'(g), 32'h4);
        req = '0;
        tick(5);
        check_val("t3_in_busy", 32'({busy, transmit}), 32'h2);
        rst_n = 1'b0;
        tick(1);
        check_val("t3_reset_outputs",
                  32'({grant, done, busy, busy_id, transmit, tx_byte, error}), 32'd0);
        rst_n          = 1'b1;
        req_byte[15:8] = 8'h22;
        req            = 4'b0010;
        flag           = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant != '0) flag = 1'b1;
            if (!is_transmitting) break;
        end
        check_val("t3_no_grant_while_line_busy", 32'(flag), 32'd0);
        wait_grant(3, g);
        check_val("t3_grant_after_idle", 32'(g), 32'h2);
        check_val("t3_byte", 32'(tx_byte), 32'h22);
        req = '0;
        wait_idle("t3_idle", 80);

        // 4: wrap from requester 3 back to 0
        req_byte[31:24] = 8'h33;
        req_byte[7:0]   = 8'h30;
        req             = 4'b1000;
        wait_grant(10, g);
        check_val("t4_grant3", 32'(g), 32'h8);
        req = 4'b1001;
        wait_grant(60, g);
        check_val("t4_wrap0", 32'(g), 32'h1);
        check_val("t4_wrap0_byte", 32'(tx_byte), 32'h30);
        wait_grant(60, g);
        check_val("t4_back3", 32'(g), 32'h8);
        req = '0;
        wait_idle("t4_idle", 80);

        // 5/6: uart never acknowledges
        model_en        = 1'b0;
        req_byte[15:8]  = 8'h55;
        req_byte[23:16] = 8'h66;
        req             = 4'b0110;
        wait_grant(10, g);
        check_val("t5_first_grant", 32'(g), 32'h2);
        req = 4'b0100;
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (error) break;
        end
        check_val("t5_timeout_cycles", 32'(n), 32'd16);
        check_val("t5_abort_outputs", 32'({error, transmit, busy}), 32'h4);
        tick(1);
        check_val("t5_next_grant", 32'(grant), 32'h4);
        check_val("t5_next_byte", 32'({error, tx_byte}), 32'h066);
        req      = '0;
        model_en = 1'b1;
        wait_idle("t5_idle", 80);
`else
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant != '0 || !transmit || !busy) flag = 1'b1;
        end
        check_val("t6_waits_forever", 32'(flag), 32'd0);
        check_val("t6_outputs", 32'({transmit, busy, error}), 32'h6);
        check_val("t6_no_error", 32'(err_seen), 32'd0);
        req      = '0;
        model_en = 1'b1;
        wait_idle("t6_idle", 80);
`endif

        check_val("no_transmit_in_busy", 32'(overlap_err), 32'd0);
        check_val("grant_onehot", 32'(onehot_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
